// File: rtl/axi_stream_arbiter.sv
// Packet-granular round-robin N:1 AXI-Stream arbiter with one registered output stage.
// A granted requester keeps the output until its TLAST beat is accepted.
module axi_stream_arbiter #(
  parameter int N_INPUTS    = 4,
  parameter int TDATA_WIDTH = 16,
  parameter int TID_WIDTH   = 2,
  parameter int TDEST_WIDTH = 3,
  parameter int TUSER_WIDTH = 8,
  localparam int KW = TDATA_WIDTH / 8,
  localparam int GW = $clog2(N_INPUTS)
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [N_INPUTS-1:0]             s_tvalid,
  output logic [N_INPUTS-1:0]             s_tready,
  input  logic [N_INPUTS*TDATA_WIDTH-1:0] s_tdata,
  input  logic [N_INPUTS*TID_WIDTH-1:0]   s_tid,
  input  logic [N_INPUTS*TDEST_WIDTH-1:0] s_tdest,
  input  logic [N_INPUTS*TUSER_WIDTH-1:0] s_tuser,
  input  logic [N_INPUTS*KW-1:0]          s_tkeep,
  input  logic [N_INPUTS*KW-1:0]          s_tstrb,
  input  logic [N_INPUTS-1:0]             s_tlast,
  input  logic [N_INPUTS-1:0]             s_twakeup,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [TDATA_WIDTH-1:0]          m_tdata,
  output logic [TID_WIDTH-1:0]            m_tid,
  output logic [TDEST_WIDTH-1:0]          m_tdest,
  output logic [TUSER_WIDTH-1:0]          m_tuser,
  output logic [KW-1:0]                   m_tkeep,
  output logic [KW-1:0]                   m_tstrb,
  output logic                            m_tlast,
  output logic                            m_twakeup,
  output logic [GW-1:0]                   grant,
  output logic                            busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, PASS = 1'b1} state_t;

  state_t                 state_r;
  logic [GW-1:0]          rr_ptr_r;
  logic [GW-1:0]          cand_s;
  logic [GW-1:0]          pick_s;
  logic                   found_s;
  logic                   out_ready_s;
  logic                   accept_s;
  logic [TDATA_WIDTH-1:0] sel_tdata_s;
  logic [TID_WIDTH-1:0]   sel_tid_s;
  logic [TDEST_WIDTH-1:0] sel_tdest_s;
  logic [TUSER_WIDTH-1:0] sel_tuser_s;
  logic [KW-1:0]          sel_tkeep_s;
  logic [KW-1:0]          sel_tstrb_s;
  logic                   sel_tlast_s;
  logic                   sel_tvalid_s;

  // Round-robin search: first valid requester strictly after the previous owner.
  always_comb begin
    cand_s  = {GW{1'b0}};
    pick_s  = rr_ptr_r;
    found_s = 1'b0;
    for (int k = 1; k <= N_INPUTS; k++) begin
      cand_s = GW'((int'(rr_ptr_r) + k) % N_INPUTS);
      if (!found_s && s_tvalid[cand_s]) begin
        pick_s  = cand_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // AND-OR mux of the granted requester's slice of every field.
  always_comb begin
    sel_tdata_s  = {TDATA_WIDTH{1'b0}};
    sel_tid_s    = {TID_WIDTH{1'b0}};
    sel_tdest_s  = {TDEST_WIDTH{1'b0}};
    sel_tuser_s  = {TUSER_WIDTH{1'b0}};
    sel_tkeep_s  = {KW{1'b0}};
    sel_tstrb_s  = {KW{1'b0}};
    sel_tlast_s  = 1'b0;
    sel_tvalid_s = 1'b0;
    for (int i = 0; i < N_INPUTS; i++) begin
      sel_tdata_s  |= s_tdata[i*TDATA_WIDTH +: TDATA_WIDTH] & {TDATA_WIDTH{grant == GW'(i)}};
      sel_tid_s    |= s_tid[i*TID_WIDTH +: TID_WIDTH]       & {TID_WIDTH{grant == GW'(i)}};
      sel_tdest_s  |= s_tdest[i*TDEST_WIDTH +: TDEST_WIDTH] & {TDEST_WIDTH{grant == GW'(i)}};
      sel_tuser_s  |= s_tuser[i*TUSER_WIDTH +: TUSER_WIDTH] & {TUSER_WIDTH{grant == GW'(i)}};
      sel_tkeep_s  |= s_tkeep[i*KW +: KW]                   & {KW{grant == GW'(i)}};
      sel_tstrb_s  |= s_tstrb[i*KW +: KW]                   & {KW{grant == GW'(i)}};
      sel_tlast_s  |= s_tlast[i]  & (grant == GW'(i));
      sel_tvalid_s |= s_tvalid[i] & (grant == GW'(i));
    end
  end

  // Only the owner sees ready, and only when the output register can take a beat.
  always_comb begin
    out_ready_s = !m_tvalid || m_tready;
    accept_s    = (state_r == PASS) && sel_tvalid_s && out_ready_s;
    for (int i = 0; i < N_INPUTS; i++) begin
      s_tready[i] = (state_r == PASS) && (grant == GW'(i)) && out_ready_s;
    end
  end

  // Arbitration FSM together with the output register stage and wakeup.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r   <= IDLE;
      busy      <= 1'b0;
      grant     <= {GW{1'b0}};
      rr_ptr_r  <= GW'(N_INPUTS - 1);
      m_tvalid  <= 1'b0;
      m_tdata   <= {TDATA_WIDTH{1'b0}};
      m_tid     <= {TID_WIDTH{1'b0}};
      m_tdest   <= {TDEST_WIDTH{1'b0}};
      m_tuser   <= {TUSER_WIDTH{1'b0}};
      m_tkeep   <= {KW{1'b0}};
      m_tstrb   <= {KW{1'b0}};
      m_tlast   <= 1'b0;
      m_twakeup <= 1'b0;
    end else begin
      m_twakeup <= (|s_twakeup) || busy || m_tvalid;
      if (accept_s) begin
        m_tvalid <= 1'b1;
        m_tdata  <= sel_tdata_s;
        m_tid    <= sel_tid_s;
        m_tdest  <= sel_tdest_s;
        m_tuser  <= sel_tuser_s;
        m_tkeep  <= sel_tkeep_s;
        m_tstrb  <= sel_tstrb_s;
        m_tlast  <= sel_tlast_s;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (found_s) begin
            grant   <= pick_s;
            state_r <= PASS;
            busy    <= 1'b1;
          end
        end
        PASS: begin
          if (accept_s && sel_tlast_s) begin
            rr_ptr_r <= grant;
            state_r  <= IDLE;
            busy     <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_stream_arbiter.md
# axi_stream_arbiter

Packet-granular, round-robin N:1 arbiter for AXI-Stream 5 sources. It shares one downstream `axi_stream_if` (16-bit TDATA, TID, TDEST, TUSER, TREADY, TLAST, TKEEP, TSTRB, TWAKEUP) between `N_INPUTS` upstream requesters. Once a requester is granted, it holds the grant until its TLAST beat has been accepted. The output is driven from a single register stage, so the output has no combinational path to the inputs apart from `s_tready`.

## Interface
- `N_INPUTS`, 4: number of upstream requesters, 2..8.
- `TDATA_WIDTH`, 16: data width in bits, a multiple of 8.
- `TID_WIDTH`, 2: TID width.
- `TDEST_WIDTH`, 3: TDEST width.
- `TUSER_WIDTH`, 8: TUSER width.
- Derived: `KW = TDATA_WIDTH/8` is the TKEEP/TSTRB width. `GW = $clog2(N_INPUTS)` is the grant index width.

Ports:
- `aclk` in 1: the single clock. All logic is on the rising edge.
- `areset` in 1: synchronous, active-high reset.
- `s_tvalid` in N_INPUTS: per-requester valid.
- `s_tready` out N_INPUTS: per-requester ready.
- `s_tdata` in N_INPUTS*TDATA_WIDTH: requester i occupies slice [i*TDATA_WIDTH +: TDATA_WIDTH]. The other packed buses use the same slicing.
- `s_tid`, `s_tdest`, `s_tuser`, `s_tkeep`, `s_tstrb` in N_INPUTS*(respective width): per-requester sideband.
- `s_tlast`, `s_twakeup` in N_INPUTS: per-requester last and wakeup.
- `m_tvalid`, `m_tready`, `m_tdata`, `m_tid`, `m_tdest`, `m_tuser`, `m_tkeep`, `m_tstrb`, `m_tlast`: downstream AXI-Stream. `m_tready` is an input; all others are outputs.
- `m_twakeup` out 1: downstream wakeup.
- `grant` out GW: index of the current or most recent owner.
- `busy` out 1: high while in PASS.

## Operation
- **FSM states:** IDLE and PASS.
- **IDLE:**
  - If any `s_tvalid` is high, choose the first requester with valid set, searching from `rr_ptr+1` upward and wrapping modulo N_INPUTS.
  - Load `grant` with that index and go to PASS on the next cycle.
  - No beat is accepted in IDLE; all `s_tready` are 0.
- **PASS:**
  - `s_tready[grant] = !m_tvalid || m_tready`. All other bits of `s_tready` are 0.
  - A beat is accepted when `s_tvalid[grant] && s_tready[grant]`. On acceptance, the granted slice of every field is registered into the output stage and `m_tvalid` is set to 1.
  - If `m_tready` is high and no beat is accepted, `m_tvalid` clears to 0.
- **End of packet:** accepting a beat with `s_tlast[grant]=1` sets `rr_ptr <= grant` and moves the FSM to IDLE.
- **Grant hold:** the grant is held across gaps where `s_tvalid[grant]` drops mid-packet; no other requester can preempt it.
- **Output stability:** while `m_tvalid && !m_tready`, every `m_*` field is held stable (AXI-Stream rule).
- **TKEEP/TSTRB** pass through unmodified. The block does not check null bytes or the position bytes.
- **Wakeup:** `m_twakeup` is a register loaded each cycle with `(|s_twakeup) || busy || m_tvalid`. It therefore asserts no later than 1 cycle before the first `m_tvalid`, provided the source raised TWAKEUP together with, or before, TVALID.
- **Reset values:**
  - `m_tvalid`, `m_tlast`, `m_twakeup` and `busy` are 0.
  - `m_tdata`, `m_tid`, `m_tdest`, `m_tuser`, `m_tkeep` and `m_tstrb` are all-zero.
  - `grant` is 0, `rr_ptr` is N_INPUTS-1 (so requester 0 has first priority), and the FSM is in IDLE.
- **Reset mid-packet:** reset abandons the packet with no flush. The output register is cleared the cycle after `areset` is sampled high. The partially sent packet is the source's responsibility.

## Timing
- **First-beat latency:** `s_tvalid` rises at cycle 0 with the block idle. Arbitration happens at edge 0→1, so `s_tready` is high in cycle 1. The beat is accepted at edge 1→2, so `m_tvalid` is high in cycle 2.
- **Throughput:** within a packet, one beat per cycle when `m_tready` is held high.
- **Inter-packet gap:** exactly one IDLE cycle with `s_tready` all zero. When several requesters are waiting, the next grant goes to the next index above the previous owner.
- **Simultaneous requests** are resolved purely by `rr_ptr`; there is no fixed priority.
- **Single-beat packets** (TLAST on the first beat) take 2 cycles per packet per requester.
- **Backpressure:** if `m_tready` is low while `m_tvalid` is high, `s_tready[grant]` is low in the same cycle (combinational). No beat is lost or duplicated.

## Test plan
- **Single requester:** after reset, requester 2 sends a 3-beat packet with TDATA 0x1111/0x2222/0x3333, TID=1, TDEST=5, TUSER=0xA5, TKEEP=TSTRB=2'b11, TLAST on beat 3, and `m_tready`=1.
  - `m_tvalid` is first high 2 cycles after `s_tvalid`; beats follow on consecutive cycles with identical fields; `grant`=2.
  - `busy` falls the cycle after the TLAST beat is accepted.
- **Fairness:** all 4 requesters hold 2-beat packets continuously. Output packet order is 0,1,2,3,0,1…, with exactly one bubble cycle between packets.
- **Preemption guard:** requester 1 owns the grant and drops `s_tvalid` for 3 cycles mid-packet while requester 0 is valid. No requester-0 beat appears until requester 1's TLAST has been accepted.
- **Backpressure:** `m_tready` toggles 1,0,0,1 during a 4-beat packet. `m_tdata` holds its value while stalled, and all 4 beats are received in order without duplicates.
- **Reset mid-packet:** `areset` is asserted for 1 cycle after beat 2 of 4. The next cycle shows `m_tvalid`=0, `busy`=0 and `m_tdata`=0. A new request from requester 3 and requester 0 in the same cycle is granted to 0 first.
- **Wakeup:** requester 1 raises TWAKEUP 2 cycles before TVALID. `m_twakeup` is 1 from the cycle after TWAKEUP is raised until the cycle after the last beat leaves the output register.
